stopwatch_core: RTL and testbench

Parametrised stopwatch engine with integrated multiplexed 7-segment display drive. It replaces the fixed four-digit driver chain (divider, counter, digit enable, decoder) with one block. It sits directly between board buttons and the 7-segment pins:
- NUM_DIGITS BCD digits, each rolling over 9→0;
- start/stop toggled on button edges;
- sticky overflow flag;
- optional lap hold that freezes the display while counting continues.

---
 rtl/stopwatch_pkg.sv | 44 ++++
 rtl/stopwatch_core_bcd_digit.sv | 31 +++
 rtl/stopwatch_core.sv | 224 ++++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch engine.
// Latency: n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
//
// Contents:
//   run_state_t : run-state enum {STOPPED, RUNNING}
//   SEG_LUT     : active-low {g..a} patterns for BCD 0..9
//   SEG_BLANK   : all segments off
//   seg_decode  : BCD code -> segment pattern; codes 10..15 give blank
package stopwatch_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Codes above 9 never arise from the BCD chain; blank them so a
    // corrupted digit is visibly dark rather than showing a bogus glyph.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (d <= 4'd9) begin
            pat = SEG_LUT[d];
        end
        return pat;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One decade of the BCD count chain: 0..9 with wrap and ripple carry.
// Latency: q updates on the clock edge after inc_in; carry_out is combinational.
// Backpressure: none; increments whenever inc_in is high.
//
// Ports:
//   clk, reset (async active-low), clr (sync clear, wins over inc_in)
//   inc_in    : advance this digit this cycle
//   q         : current digit value 0..9
//   carry_out : inc_in && q==9, i.e. the next digit should advance too
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc_in,
    output logic [3:0] q,
    output logic       carry_out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc_in) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry_out = inc_in && (q == 4'd9);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: button sync/edge detect, run FSM, BCD count, 7-seg scan.
// Latency: buttons act 3 cycles after rising; display outputs are registered (1 cycle).
// Backpressure: none; free-running, inputs are level/edge sampled every cycle.
//
// Optional feature: define STOPWATCH_LAP_EN to enable the lap hold (display
// snapshot frozen while counting continues). Without it the lap input is
// ignored and the display always shows the live count.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low
//   start    : raw button; each rising edge toggles run/stop
//   clear    : raw level; while high clears counts, overflow, hold and stops
//   lap      : raw button; rising edge toggles display hold (lap builds only)
//   seg      : {g..a}, active-low, registered
//   decimal  : decimal point, active-low, registered
//   an       : digit enables, active-low one-hot, registered
//   running  : high while counting
//   overflow : sticky wrap flag from all-9s to all-0s
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 1_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int DP_POS      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  lap,
    output logic [6:0]            seg,
    output logic                  decimal,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  running,
    output logic                  overflow
);

    localparam int TW    = $clog2(TICK_DIV);
    localparam int RW    = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0]    REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Input synchronisers. start uses a third flop for edge detection;
    // clear is consumed as a level so it stops at the synchronised stage,
    // which keeps its action aligned with start/lap edges (3 cycles).
    // ------------------------------------------------------------------
    logic [2:0] start_sr;
    logic [1:0] clear_sr;
    logic       start_edge;
    logic       clear_lvl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_sr <= 3'b000;
            clear_sr <= 2'b00;
        end else begin
            start_sr <= {start_sr[1:0], start};
            clear_sr <= {clear_sr[0], clear};
        end
    end

    assign start_edge = start_sr[1] & ~start_sr[2];
    assign clear_lvl  = clear_sr[1];

    // ------------------------------------------------------------------
    // Run-state FSM
    // ------------------------------------------------------------------
    run_state_t state_q;
    run_state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // clear has priority over a start edge in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clear_lvl) begin
            state_d = STOPPED;
        end else if (start_edge) begin
            state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
        end
    end

    always_comb begin
        running = (state_q == RUNNING);
    end

    // ------------------------------------------------------------------
    // Tick prescaler. Holds while stopped so a restart resumes mid-period.
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = running && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (clear_lvl) begin
            tick_cnt <= '0;
        end else if (running) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // BCD count chain: inc[k] is the advance for digit k; inc[NUM_DIGITS]
    // fires only when every digit wraps, which is the overflow event.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS:0]          inc;
    logic [NUM_DIGITS-1:0][3:0]   digits;

    assign inc[0] = tick;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (clear_lvl),
            .inc_in    (inc[g]),
            .q         (digits[g]),
            .carry_out (inc[g+1])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (clear_lvl) begin
            overflow <= 1'b0;
        end else if (inc[NUM_DIGITS]) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display source: live digits, or the lap snapshot while held.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][3:0] shown;

`ifdef STOPWATCH_LAP_EN
    logic [2:0]                 lap_sr;
    logic                       lap_edge;
    logic                       hold;
    logic [NUM_DIGITS-1:0][3:0] snap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_sr <= 3'b000;
        end else begin
            lap_sr <= {lap_sr[1:0], lap};
        end
    end

    assign lap_edge = lap_sr[1] & ~lap_sr[2];

    // First lap edge freezes the current count, second releases it.
    // clear drops the hold even if a lap edge lands in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold <= 1'b0;
            snap <= '0;
        end else if (clear_lvl) begin
            hold <= 1'b0;
        end else if (lap_edge) begin
            if (!hold) begin
                snap <= digits;
                hold <= 1'b1;
            end else begin
                hold <= 1'b0;
            end
        end
    end

    assign shown = hold ? snap : digits;
`else
    // lap exists on the pinout for board compatibility but has no function.
    logic lap_unused;
    assign lap_unused = lap;
    assign shown      = digits;
`endif

    // ------------------------------------------------------------------
    // Multiplexed scan: refresh counter free-runs regardless of run state.
    // ------------------------------------------------------------------
    logic [RW-1:0]    ref_cnt;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an      <= '1;
            seg     <= SEG_BLANK;
            decimal <= 1'b1;
        end else begin
            an      <= ~(NUM_DIGITS'(1) << idx);
            seg     <= seg_decode(shown[idx]);
            decimal <= (int'(idx) == DP_POS) ? 1'b0 : 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear;
    logic       lap;
    logic [6:0] seg;
    logic       decimal;
    logic [3:0] an;
    logic       running;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_q[$];

    stopwatch_core #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (4),
        .REFRESH_DIV (2),
        .DP_POS      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .lap      (lap),
        .seg      (seg),
        .decimal  (decimal),
        .an       (an),
        .running  (running),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after clock edge number t.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample point: falling edge following clock edge number t.
    task automatic sample_at(input int t);
        goto(t);
        @(negedge clk);
    endtask

    task automatic press_start();
        int t0;
        t0 = cyc;
        start = 1'b1;
        goto(t0 + 2);
        start = 1'b0;
    endtask

    task automatic press_lap();
        int t0;
        t0 = cyc;
        lap = 1'b1;
        goto(t0 + 2);
        lap = 1'b0;
    endtask

    function automatic logic [3:0] seg_to_dig(input logic [6:0] s);
        case (s)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            default:    return 4'hE;
        endcase
    endfunction

    // Watch one full scan (each digit lit 2 cycles) and rebuild the shown
    // number from an/seg; compare against the oldest queued expectation.
    task automatic read_display(input string tag);
        logic [15:0] got;
        logic [15:0] exp;
        logic        dp_bad;
        logic        dp_exp;
        got    = 16'hFFFF;
        dp_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: got[3:0]   = seg_to_dig(seg);
                4'b1101: got[7:4]   = seg_to_dig(seg);
                4'b1011: got[11:8]  = seg_to_dig(seg);
                4'b0111: got[15:12] = seg_to_dig(seg);
                default: dp_bad     = 1'b1;
            endcase
            dp_exp = (an == 4'b1011) ? 1'b0 : 1'b1;
            if (decimal !== dp_exp) dp_bad = 1'b1;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=%0h", tag, got);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, 32'(got), 32'(exp));
        end
        chk({tag, "_dp_an"}, 32'(dp_bad), 32'(1'b0));
    endtask

    initial begin
        int          k0;
        int          p;
        int          e;
        int          r;
        int          c;
        int          r2;
        int          r3;
        logic [3:0]  exp_an;

        reset = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_an", 32'(an), 32'(4'hF));
        chk("rst_seg", 32'(seg), 32'(7'h7F));
        chk("rst_dp", 32'(decimal), 32'(1'b1));
        chk("rst_running", 32'(running), 32'(1'b0));
        chk("rst_overflow", 32'(overflow), 32'(1'b0));

        // Release and watch the scan order
        @(posedge clk);
        #1;
        reset = 1'b1;
        k0 = cyc;
        for (int k = 0; k < 8; k++) begin
            sample_at(k0 + 1 + k);
            exp_an = ~(4'b0001 << (k / 2));
            chk("scan_an", 32'(an), 32'(exp_an));
            chk("scan_dp", 32'(decimal), 32'(((k / 2) == 2) ? 1'b0 : 1'b1));
            if (k == 0) chk("first_seg", 32'(seg), 32'(7'b1000000));
        end
        chk("idle_running", 32'(running), 32'(1'b0));
        exp_q.push_back(16'h0000);
        read_display("idle_disp");

        // Start: running 3 cycles after press, first increment 4 later
        p = cyc;
        press_start();
        sample_at(p + 2);
        chk("start_lat_lo", 32'(running), 32'(1'b0));
        sample_at(p + 3);
        chk("start_lat_hi", 32'(running), 32'(1'b1));
        e = p + 3;
        sample_at(e + 3);
        chk("cnt_before_tick", 32'(dut.digits), 32'(16'h0000));
        sample_at(e + 4);
        chk("cnt_first_tick", 32'(dut.digits), 32'(16'h0001));

        // Stop so that 40 ticks have elapsed and the prescaler sits at 2
        goto(e + 159);
        press_start();
        sample_at(e + 161);
        chk("stop_lat_hi", 32'(running), 32'(1'b1));
        sample_at(e + 162);
        chk("stop_lat_lo", 32'(running), 32'(1'b0));
        goto(e + 262);
        chk("frozen_cnt", 32'(dut.digits), 32'(16'h0040));
        exp_q.push_back(16'h0040);
        read_display("disp_0040");

        // Resume: prescaler resumes at 2 so next increment is 2 clk later
        p = cyc;
        press_start();
        r = p + 3;
        sample_at(r + 1);
        chk("resume_hold", 32'(dut.digits), 32'(16'h0040));
        sample_at(r + 2);
        chk("resume_inc", 32'(dut.digits), 32'(16'h0041));

        // Run through 9999 -> 0000 with sticky overflow
        sample_at(r + 39837);
        chk("pre_wrap_cnt", 32'(dut.digits), 32'(16'h9999));
        chk("pre_wrap_ovf", 32'(overflow), 32'(1'b0));
        sample_at(r + 39838);
        chk("wrap_cnt", 32'(dut.digits), 32'(16'h0000));
        chk("wrap_ovf", 32'(overflow), 32'(1'b1));
        sample_at(r + 39842);
        chk("post_wrap_cnt", 32'(dut.digits), 32'(16'h0001));
        chk("post_wrap_ovf", 32'(overflow), 32'(1'b1));

        // Clear
        c = cyc;
        clear = 1'b1;
        sample_at(c + 2);
        chk("clear_lat_ovf", 32'(overflow), 32'(1'b1));
        sample_at(c + 3);
        chk("clear_running", 32'(running), 32'(1'b0));
        chk("clear_ovf", 32'(overflow), 32'(1'b0));
        chk("clear_cnt", 32'(dut.digits), 32'(16'h0000));
        goto(c + 5);
        clear = 1'b0;
        goto(cyc + 4);
        exp_q.push_back(16'h0000);
        read_display("clear_disp");

        // Lap hold while counting
        p = cyc;
        press_start();
        r2 = p + 3;
        goto(r2 + 48);
        press_lap();
        goto(r2 + 54);
`ifdef STOPWATCH_LAP_EN
        exp_q.push_back(16'h0012);
        read_display("lap_hold_running");
`endif
        goto(r2 + 78);
        press_start();
        sample_at(r2 + 84);
        chk("lap_stop_running", 32'(running), 32'(1'b0));
        chk("lap_live_cnt", 32'(dut.digits), 32'(16'h0020));
`ifdef STOPWATCH_LAP_EN
        exp_q.push_back(16'h0012);
`else
        exp_q.push_back(16'h0020);
`endif
        read_display("lap_hold_stopped");
        press_lap();
        goto(cyc + 4);
        exp_q.push_back(16'h0020);
        read_display("lap_release");

        // clear and lap rising together: clear must win, no hold
        clear = 1'b1;
        lap   = 1'b1;
        goto(cyc + 5);
        clear = 1'b0;
        lap   = 1'b0;
        goto(cyc + 4);
        exp_q.push_back(16'h0000);
        read_display("clear_beats_lap");

        // Asynchronous reset mid-count at 0537 (with hold in lap builds)
        p = cyc;
        press_start();
        r3 = p + 3;
`ifdef STOPWATCH_LAP_EN
        goto(r3 + 2140);
        press_lap();
`endif
        sample_at(r3 + 2150);
        chk("pre_reset_cnt", 32'(dut.digits), 32'(16'h0537));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'(4'hF));
        chk("arst_seg", 32'(seg), 32'(7'h7F));
        chk("arst_dp", 32'(decimal), 32'(1'b1));
        chk("arst_running", 32'(running), 32'(1'b0));
        chk("arst_overflow", 32'(overflow), 32'(1'b0));
        chk("arst_cnt", 32'(dut.digits), 32'(16'h0000));
        @(posedge clk);
        #1;
        reset = 1'b1;
        goto(cyc + 4);
        exp_q.push_back(16'h0000);
        read_display("post_reset_disp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
